// File: rtl/axi_pkg.sv
// Shared constants, FSM state codes and the captured-request type for the npc AXI4 memory master.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_4B    = 3'd2;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t AR   = 3'd1;
    localparam state_t R    = 3'd2;
    localparam state_t AWW  = 3'd3;
    localparam state_t B    = 3'd4;

    typedef struct packed {
        logic [7:0] len;
        logic [3:0] wstrb;
    } req_t;

endpackage

// File: rtl/axi_rsp_skid.sv
// One-entry response register: holds a read/write response beat until the consumer takes it.
module axi_rsp_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_err,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              err
);

    // The master only loads when the entry is empty or being drained this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
            err   <= load_err;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_mem_master.sv
// Single-outstanding AXI4 master: INCR burst reads, single-beat writes, responses on a valid/ready stream.
// Define AXI_MASTER_CHECK_EN to flag rid/bid and rlast protocol errors on rsp_err.
module axi_mem_master
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 32,
    parameter logic [2:0] SIZE   = SIZE_4B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [3:0]        arid,
    output logic [1:0]        arbrust,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic              ready,
    input  logic [3:0]        rid,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        awid,
    output logic [1:0]        awbrust,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    output logic [3:0]        wstrb,
    output logic              bready,
    input  logic              bvalid,
    input  logic [3:0]        bresp,
    input  logic [3:0]        bid
);

    state_t     state;
    req_t       cap;
    logic [7:0] beat_cnt;
    logic       aw_done;
    logic       w_done;
    logic       r_fire;
    logic       b_fire;
    logic       aw_fire;
    logic       w_fire;
    logic       r_end;
    logic       r_err;
    logic       b_err;

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arbrust = BURST_INCR;
    assign awbrust = BURST_INCR;
    assign arsize  = SIZE;
    assign awsize  = SIZE;
    assign awlen   = 8'd0;
    assign wlast   = 1'b1;
    assign wstrb   = cap.wstrb;

    // A new request waits until the previous response has left the skid register.
    assign req_ready = (state == IDLE) && !rsp_valid;
    assign ready     = (state == R) && (!rsp_valid || rsp_ready);
    assign bready    = (state == B);

    assign r_fire  = rvalid && ready;
    assign b_fire  = bvalid && bready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

`ifdef AXI_MASTER_CHECK_EN
    logic [1:0] unused_bits;
    assign unused_bits = bresp[3:2];
    assign r_end = (beat_cnt == cap.len);
    assign r_err = (rresp != RESP_OKAY) || (rid != AXI_ID) || (rlast != (beat_cnt == cap.len));
    assign b_err = (bresp[1:0] != RESP_OKAY) || (bid != AXI_ID);
`else
    logic [17:0] unused_bits;
    assign unused_bits = {rid, bid, bresp[3:2], cap.len};
    assign r_end = rlast;
    assign r_err = (rresp != RESP_OKAY);
    assign b_err = (bresp[1:0] != RESP_OKAY);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap      <= '0;
            beat_cnt <= 8'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            arvalid  <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            araddr   <= '0;
            arlen    <= 8'd0;
            awaddr   <= '0;
            wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cap.len   <= req_len;
                        cap.wstrb <= req_wstrb;
                        beat_cnt  <= 8'd0;
                        if (req_we) begin
                            awaddr  <= req_addr;
                            wdata   <= req_wdata;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= AWW;
                        end else begin
                            araddr  <= req_addr;
                            arlen   <= req_len;
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= R;
                    end
                end
                R: begin
                    if (r_fire) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (r_end) state <= IDLE;
                    end
                end
                AWW: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) state <= B;
                end
                B: begin
                    if (bvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_rsp_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (r_fire || b_fire),
        .load_data ((state == R) ? rdata : '0),
        .load_last ((state == R) ? r_end : 1'b1),
        .load_err  ((state == R) ? r_err : b_err),
        .ready     (rsp_ready),
        .valid     (rsp_valid),
        .data      (rsp_data),
        .last      (rsp_last),
        .err       (rsp_err)
    );

endmodule

// File: tb/tb_axi_mem_master.sv
// Self-checking bench for axi_mem_master: directed scenarios plus randomized traffic against a
// transaction-level model of the expected response stream and a reactive AXI slave.
module tb_axi_mem_master;

    localparam logic [3:0] AXI_ID = 4'd0;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_data;
    logic [63:0] araddr, awaddr;
    logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic [3:0]  arid, awid, rid, bid, bresp, wstrb;
    logic [1:0]  arbrust, awbrust, rresp;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [31:0] rdata, wdata;
    logic        rvalid, ready, rlast, bready, bvalid;

    axi_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arbrust(arbrust), .arlen(arlen), .arsize(arsize),
        .rdata(rdata), .rvalid(rvalid), .ready(ready), .rid(rid), .rlast(rlast), .rresp(rresp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
        .awbrust(awbrust), .awlen(awlen), .awsize(awsize),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t expQ[$];
    beat_t popped;
    int    errors = 0;
    int    checks = 0;

    // Current transaction as the model sees it
    logic        txWe;
    logic [63:0] txAddr;
    int          txLen, txRlastAt, nBeats;
    logic [31:0] txData [256];
    logic [1:0]  txResp [256];
    logic [31:0] txWdata;
    logic [3:0]  txWstrb;
    logic [1:0]  txBresp;
    int          arLat, awLat, wLat, bLat, rGapPct, readyMode;

    // Slave/handshake bookkeeping
    logic reqPending, reqFire, rFired, bFired;
    logic arSeen, arGot, awSeen, awGot, wSeen, wGot, bDone;
    int   arCnt, awCnt, wCnt, bCnt, rIdx;

    task checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task resetModel();
        reqPending = 0; reqFire = 0; rFired = 0; bFired = 0;
        arSeen = 0; arGot = 0; awSeen = 0; awGot = 0; wSeen = 0; wGot = 0; bDone = 0;
        arCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0; rIdx = 0;
        rvalid = 0; bvalid = 0; req_valid = 0;
    endtask

    task setTxn(input logic we, input logic [63:0] addr, input int len);
        txWe = we; txAddr = addr; txLen = len; txRlastAt = len;
        for (int i = 0; i < 256; i++) begin
            txData[i] = $urandom;
            txResp[i] = 2'b00;
        end
        txWdata = $urandom; txWstrb = 4'($urandom_range(15)); txBresp = 2'b00;
        arLat = 0; awLat = 0; wLat = 0; bLat = 0; rGapPct = 0; readyMode = 0;
    endtask

    // Expected response stream derived from the transaction description alone
    task buildExpected();
        beat_t b;
        expQ.delete();
        if (txWe) begin
            nBeats = 0;
            b.data = 32'd0; b.last = 1'b1; b.err = (txBresp != 2'b00);
            expQ.push_back(b);
        end else begin
`ifdef AXI_MASTER_CHECK_EN
            nBeats = txLen + 1;
            for (int i = 0; i < nBeats; i++) begin
                b.data = txData[i];
                b.last = (i == txLen);
                b.err  = (txResp[i] != 2'b00) || ((i == txRlastAt) != (i == txLen));
                expQ.push_back(b);
            end
`else
            nBeats = txRlastAt + 1;
            for (int i = 0; i < nBeats; i++) begin
                b.data = txData[i];
                b.last = (i == txRlastAt);
                b.err  = (txResp[i] != 2'b00);
                expQ.push_back(b);
            end
`endif
        end
    endtask

    task startTxn();
        resetModel();
        buildExpected();
        req_we = txWe; req_addr = txAddr; req_len = 8'(txLen);
        req_wdata = txWdata; req_wstrb = txWstrb;
        reqPending = 1;
    endtask

    // One clock of slave + consumer: observe at negedge, drive, then resolve handshakes before posedge
    task cycle();
        @(negedge clk);
        if (reqFire) begin
            if (txWe) begin
                checkOutput("awvalid_lat", awvalid, 1);
                checkOutput("wvalid_lat", wvalid, 1);
            end else begin
                checkOutput("arvalid_lat", arvalid, 1);
            end
            reqFire = 0;
        end
        if (rFired) begin checkOutput("rsp_lat_r", rsp_valid, 1); rvalid = 0; rFired = 0; end
        if (bFired) begin checkOutput("rsp_lat_b", rsp_valid, 1); bvalid = 0; bFired = 0; end
        if (arGot) checkOutput("arvalid_drop", arvalid, 0);
        else if (arSeen) checkOutput("arvalid_hold", arvalid, 1);
        if (awGot) checkOutput("awvalid_drop", awvalid, 0);
        else if (awSeen) checkOutput("awvalid_hold", awvalid, 1);
        if (wGot) checkOutput("wvalid_drop", wvalid, 0);
        else if (wSeen) checkOutput("wvalid_hold", wvalid, 1);
        if (txWe && !(awGot && wGot)) checkOutput("bready_early", bready, 0);
        if (!txWe && arGot && rIdx < nBeats && !rsp_valid) checkOutput("ready_free", ready, 1);

        req_valid = reqPending;
        arready = arvalid && (arCnt >= arLat);
        awready = awvalid && (awCnt >= awLat);
        wready  = wvalid && (wCnt >= wLat);
        if (arGot && !rvalid && rIdx < nBeats) rvalid = (int'($urandom_range(99)) >= rGapPct);
        if (rvalid) begin
            rdata = txData[rIdx];
            rlast = (rIdx == txRlastAt);
            rresp = txResp[rIdx];
        end
        if (awGot && wGot && !bDone && !bvalid) begin
            if (bCnt >= bLat) bvalid = 1;
            bCnt++;
        end
        bresp = {2'b00, txBresp};
        case (readyMode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = !rsp_ready;
            default: rsp_ready = 1'($urandom_range(1));
        endcase
        #1;
        if (rsp_valid && !rsp_ready) checkOutput("ready_bp", ready, 0);
        if (reqPending && req_ready) begin reqPending = 0; reqFire = 1; end
        if (arvalid) begin
            arSeen = 1; arCnt++;
            if (arready) begin
                checkOutput("araddr", araddr, txAddr);
                checkOutput("arlen", arlen, 64'(txLen));
                checkOutput("arburst", arbrust, 2'b01);
                checkOutput("arsize", arsize, 3'd2);
                checkOutput("arid", arid, AXI_ID);
                arGot = 1;
            end
        end
        if (awvalid) begin
            awSeen = 1; awCnt++;
            if (awready) begin
                checkOutput("awaddr", awaddr, txAddr);
                checkOutput("awlen", awlen, 0);
                checkOutput("awburst", awbrust, 2'b01);
                checkOutput("awsize", awsize, 3'd2);
                checkOutput("awid", awid, AXI_ID);
                awGot = 1;
            end
        end
        if (wvalid) begin
            wSeen = 1; wCnt++;
            if (wready) begin
                checkOutput("wdata", wdata, txWdata);
                checkOutput("wstrb", wstrb, txWstrb);
                checkOutput("wlast", wlast, 1);
                wGot = 1;
            end
        end
        if (rvalid && ready) begin rIdx++; rFired = 1; end
        if (bvalid && bready) begin bDone = 1; bFired = 1; end
        if (rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_extra", rsp_valid, 0);
            end else begin
                popped = expQ.pop_front();
                checkOutput("rsp_data", rsp_data, popped.data);
                checkOutput("rsp_last", rsp_last, popped.last);
                checkOutput("rsp_err", rsp_err, popped.err);
            end
        end
    endtask

    task applyStimulus();
        int   cyc;
        logic done;
        startTxn();
        cyc = 0;
        done = 0;
        while (!done && cyc < 5000) begin
            cycle();
            cyc++;
            done = !reqPending && (expQ.size() == 0) && (txWe ? bDone : (arGot && rIdx == nBeats));
        end
        checkOutput("txn_done", done, 1);
    endtask

    initial begin
        int cyc;
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0; arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = 0; rlast = 0;
        rresp = 0; rid = AXI_ID; bid = AXI_ID; bvalid = 0; bresp = 0;
        setTxn(0, 64'd0, 0);
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_rready", ready, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        rst = 0;

        $display("[TB] single-beat read");
        setTxn(0, 64'h8000_0000, 0);
        txData[0] = 32'hDEAD_BEEF;
        applyStimulus();

        $display("[TB] 4-beat read with toggling rsp_ready");
        setTxn(0, 64'h8000_0100, 3);
        readyMode = 1;
        applyStimulus();

        $display("[TB] write with delayed awready");
        setTxn(1, 64'h8000_0200, 0);
        txWdata = 32'h1234_5678; txWstrb = 4'b0011; awLat = 3;
        applyStimulus();

        $display("[TB] error responses");
        setTxn(1, 64'h8000_0300, 0);
        txBresp = 2'b10;
        applyStimulus();
        setTxn(0, 64'h8000_0400, 3);
        txResp[2] = 2'b11;
        applyStimulus();

        $display("[TB] 256-beat read");
        setTxn(0, 64'h8000_1000, 255);
        readyMode = 2; rGapPct = 20;
        applyStimulus();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            setTxn(1'($urandom_range(1)), {$urandom, $urandom}, 0);
            if (!txWe) begin
                txLen = $urandom_range(7);
                txRlastAt = txLen;
            end
            for (int i = 0; i <= txLen; i++)
                if ($urandom_range(5) == 0) txResp[i] = 2'($urandom_range(1, 3));
            if ($urandom_range(3) == 0) txBresp = 2'($urandom_range(1, 3));
            arLat = $urandom_range(3); awLat = $urandom_range(3);
            wLat = $urandom_range(3); bLat = $urandom_range(3);
            rGapPct = $urandom_range(50); readyMode = $urandom_range(2);
            applyStimulus();
        end

        $display("[TB] reset during read burst");
        setTxn(0, 64'h8000_2000, 7);
        startTxn();
        cyc = 0;
        while (rIdx < 1 && cyc < 200) begin
            cycle();
            cyc++;
        end
        checkOutput("rst_setup_beat", rIdx, 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        checkOutput("midrst_arvalid", arvalid, 0);
        checkOutput("midrst_awvalid", awvalid, 0);
        checkOutput("midrst_wvalid", wvalid, 0);
        checkOutput("midrst_rready", ready, 0);
        checkOutput("midrst_bready", bready, 0);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        resetModel();
        expQ.delete();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checkOutput("postrst_req_ready", req_ready, 1);
        checkOutput("postrst_rsp_valid", rsp_valid, 0);
        setTxn(0, 64'h8000_3000, 2);
        applyStimulus();

`ifdef AXI_MASTER_CHECK_EN
        $display("[TB] early rlast with checking enabled");
        setTxn(0, 64'h8000_4000, 3);
        txRlastAt = 1;
        applyStimulus();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
